// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Handshaked RV32I data-memory controller. Byte/half/word
//               loads (sign/zero extended) and stores, configurable read
//               latency, fault flagging, zeroing sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int DEPTH_BYTES  = 1024,  // power of two, >= 8
  parameter int READ_LATENCY = 2      // 1..4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
);

  localparam int            AW       = $clog2(DEPTH_BYTES);
  localparam int            WORDS    = DEPTH_BYTES / 4;
  localparam int            IW       = AW - 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
  localparam logic [2:0]    LAT_LOAD = 3'(READ_LATENCY - 1);
  localparam bit            LAT1     = (READ_LATENCY == 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [WORDS];

  // Request decode
  logic [IW-1:0] widx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          misaligned;
  logic          bad_f3;
  logic          req_err;
  logic          accept;
  logic          st_we;
  logic [3:0]    st_be;
  logic [31:0]   st_data;
  logic [31:0]   rd_word;
  logic [31:0]   sh_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;

  assign widx = req_addr[AW-1:2];
  assign lane = req_addr[1:0];

  // Upper address bits only matter for the range check.
  generate
    if (AW < 32) begin : g_range
      assign out_of_range = |req_addr[31:AW];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  // Legal funct3 encodings differ between loads and stores.
  always_comb begin
    bad_f3 = 1'b1;
    if (req_we) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
        default:                bad_f3 = 1'b1;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_f3 = 1'b0;
        default:                                bad_f3 = 1'b1;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal encoding.
  assign misaligned = ((req_funct3[1:0] == 2'b10) && (lane != 2'b00)) ||
                      ((req_funct3[1:0] == 2'b01) && lane[0]);
  assign req_err    = bad_f3 | misaligned | out_of_range;
  assign accept     = req_valid && (state_q == S_IDLE);
  assign st_we      = accept && req_we && !req_err;

  // Store lane enables and lane-replicated store data.
  always_comb begin
    st_be   = 4'b0000;
    st_data = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << lane;
        st_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        st_be   = 4'b1111;
        st_data = req_wdata;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = req_wdata;
      end
    endcase
  end

  assign rd_word = mem_q[widx];
  assign sh_word = rd_word >> {lane, 3'b000};
  assign ld_byte = sh_word[7:0];
  assign ld_half = sh_word[15:0];

  // Lane selection and extension of the load result.
  always_comb begin
    ld_data = '0;
    case (req_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = '0;
    endcase
  end

  // Next-state logic: sweep, accept, latency countdown, response handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_INIT: begin
        // The index parks on the last word; only reset rewinds it.
        if (idx_q == LAST_IDX) state_d = S_IDLE;
        else                   idx_d   = idx_q + IW'(1);
      end
      S_IDLE: begin
        if (req_valid) begin
          err_d   = req_err;
          rdata_d = (req_we || req_err) ? 32'd0 : ld_data;
          if (req_we || LAT1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        // Leave on the edge where the count reaches zero.
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage: zeroing sweep in INIT, lane-masked writes for accepted stores.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_INIT) begin
        mem_q[idx_q] <= 32'd0;
      end else if (st_we) begin
        for (int b = 0; b < 4; b++) begin
          if (st_be[b]) mem_q[widx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign init_busy = (state_q == S_INIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Self-checking bench for dmem_ctrl (64 bytes, latency 3).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_ctrl;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_busy (init_busy)
  );

  int checks = 0;
  int errors = 0;
  bit [7:0] ref_mem [DEPTH];

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rd;
    bit        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: byte-addressed array, access rules written out directly.
  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] wdata, output bit [31:0] rd, output bit err);
    int     size;
    bit     sgn;
    longint v;
    rd = 0; err = 0; size = 0; sgn = 0;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end
    if (size == 0) err = 1;
    else if ((addr % size) != 0) err = 1;
    else if (addr >= DEPTH) err = 1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end else begin
      v = 0;
      for (int i = size - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
      if (sgn && v >= (longint'(1) << (8*size - 1))) v = v - (longint'(1) << (8*size));
      rd = v[31:0];
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (req_ready !== 1'b1) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // One full transaction: latency, result, optional backpressure, return to idle.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wdata, input int hold,
                        input bit [31:0] exp_rd, input bit exp_err);
    int n;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
    check("latency", n, we ? 1 : LAT);
    check("rdata", rsp_rdata, exp_rd);
    check("err", {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_err", {31'd0, rsp_err}, {31'd0, exp_err});
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("back_to_idle", {30'd0, rsp_valid, req_ready}, 32'd1);
  endtask

  task automatic sweep_check(input string name);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (init_busy === 1'b1 && n < 100) begin
      step();
      n++;
      if (rsp_valid === 1'b1) seen = 1;
    end
    check(name, n, DEPTH / 4);
    check("no_stale_rsp", {31'd0, seen}, 32'd0);
    check("ready_after_sweep", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] mrd;
    bit        merr;
    bit        rwe;
    bit [2:0]  rf3;
    bit [31:0] raddr;
    bit [31:0] rwd;

    // Reset state
    step(); step();
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_init_busy", {31'd0, init_busy}, 32'd1);
    rst = 1'b0;
    sweep_check("init_sweep_len");

    // Directed vectors
    vecs.push_back('{1'b0, 3'b010, 32'h00, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h3C, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h12, 32'h0, 32'h000000FF, 1'b0});
    vecs.push_back('{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0});
    vecs.push_back('{1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h10, 32'h0, 32'h80FF7F01, 1'b0});
    vecs.push_back('{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 3'b000, 32'h21, 32'h000000AA, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h05, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'b001, 32'h07, 32'h00001234, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'b010, 32'h04, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'b100, 32'h00, 32'hFFFFFFFF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 3'b101, 32'h13, 32'h0, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 3'b000, 32'h3F, 32'h1234565A, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 3'b100, 32'h3F, 32'h0, 32'h0000005A, 1'b0});
    vecs.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1});
    foreach (vecs[i]) begin
      model(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, mrd, merr);
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 0, vecs[i].rd, vecs[i].err);
    end

    // Backpressure: response held for 5 cycles
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, 32'h80FF7F01, 1'b0);

    // Request presented during the response handshake waits one cycle
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    step();
    model(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, mrd, merr);
    req_funct3 = 3'b000; req_addr = 32'h31; req_wdata = 32'h00000077;
    rsp_ready = 1'b1;
    step();
    check("overlap_not_accepted", {30'd0, rsp_valid, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    model(1'b1, 3'b000, 32'h31, 32'h00000077, mrd, merr);
    check("overlap_accepted_next", {30'd0, rsp_valid, req_ready}, 32'd2);
    step();
    rsp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h30, 32'h0, 0, 32'hCAFE770D, 1'b0);

    // Reset while a store response is pending
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h08; req_wdata = 32'hDEADBEEF;
    step();
    req_valid = 1'b0;
    check("pre_reset_resp", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    step();
    check("reset_drops_resp", {31'd0, rsp_valid}, 32'd0);
    check("reset_init_busy", {31'd0, init_busy}, 32'd1);
    step();
    rst = 1'b0;
    sweep_check("resweep_len");
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 0, 32'h0, 1'b0);

    // Randomised traffic against the reference model
    for (int k = 0; k < 150; k++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      rwd = $urandom;
      model(rwe, rf3, raddr, rwd, mrd, merr);
      do_req(rwe, rf3, raddr, rwd, $urandom_range(0, 2), mrd, merr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
